// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction-fetch stage. Issues word-aligned fetch requests to instruction
//   memory and captures the returned words into the IF/ID pipeline register.
//   A one-entry skid buffer absorbs a word returned while decode is stalled.
//   A taken branch squashes everything in flight and redirects the pc. If a
//   request is still outstanding, the stage drains that request before
//   fetching at the new pc.
//
// Ports:
//   clk            in   1   sole clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   imem_req       out  1   fetch request to instruction memory
//   imem_addr      out  32  word-aligned fetch address
//   imem_ack       in   1   memory response strobe (qualified by imem_req)
//   imem_rdata     in   32  fetched instruction word, valid with imem_ack
//   stall          in   1   decode cannot accept; IF/ID holds
//   branch_taken   in   1   single-cycle redirect pulse
//   branch_target  in   32  redirect address, bits [1:0] ignored
//   IF_ID_valid    out  1   IF/ID register holds a live instruction
//   IF_ID_instr    out  32  registered instruction word
//   IF_ID_pc       out  32  address of IF_ID_instr
//   OPcode         out  7   IF_ID_instr[6:0] when valid, else zero
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        IF_ID_valid,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_pc,
   output logic [6:0]  OPcode
);

   localparam logic [31:0] L_RESET_PC = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_BOOT  = 2'b00,
      S_FETCH = 2'b01,
      S_DRAIN = 2'b10
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;          // architectural next-fetch pc
   logic [31:0] r_addr;        // address presented to memory
   logic        r_req;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   logic [6:0]  r_opcode;
   logic        r_skid_valid;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;

   logic [31:0] w_target;
   logic [31:0] w_pc_inc;
   logic        w_ack;

   assign w_target = branch_target & 32'hFFFF_FFFC;
   assign w_pc_inc = r_addr + 32'd4;     // wraps naturally at 2^32
   assign w_ack    = imem_ack & r_req;   // acks without a live request are ignored

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign IF_ID_valid = r_ifid_valid;
   assign IF_ID_instr = r_ifid_instr;
   assign IF_ID_pc    = r_ifid_pc;
   assign OPcode      = r_opcode;

   // Fetch FSM, IF/ID register and skid buffer.
   // In DRAIN the old request stays on the bus with a stable address until its
   // ack arrives; r_pc already holds the redirect target and is copied into
   // r_addr when the drain completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_BOOT;
         r_pc         <= L_RESET_PC;
         r_addr       <= L_RESET_PC;
         r_req        <= 1'b0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= 32'h0000_0000;
         r_ifid_pc    <= 32'h0000_0000;
         r_opcode     <= 7'b000_0000;
         r_skid_valid <= 1'b0;
         r_skid_instr <= 32'h0000_0000;
         r_skid_pc    <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_BOOT: begin
               // request is low here, so any stale ack is ignored
               r_state <= S_FETCH;
               r_req   <= 1'b1;
            end

            S_FETCH: begin
               if (branch_taken) begin
                  r_ifid_valid <= 1'b0;
                  r_opcode     <= 7'b000_0000;
                  r_skid_valid <= 1'b0;
                  r_pc         <= w_target;
                  r_req        <= 1'b1;
                  if (r_req && !imem_ack) begin
                     // outstanding request: keep it on the bus until acked
                     r_state <= S_DRAIN;
                  end else begin
                     r_addr <= w_target;
                  end
               end else if (w_ack) begin
                  r_pc   <= w_pc_inc;
                  r_addr <= w_pc_inc;
                  if (!r_ifid_valid || !stall) begin
                     r_ifid_valid <= 1'b1;
                     r_ifid_instr <= imem_rdata;
                     r_ifid_pc    <= r_addr;
                     r_opcode     <= imem_rdata[6:0];
                     r_req        <= 1'b1;
                  end else begin
                     // decode is full and stalled: park the word, stop fetching
                     r_skid_valid <= 1'b1;
                     r_skid_instr <= imem_rdata;
                     r_skid_pc    <= r_addr;
                     r_req        <= 1'b0;
                  end
               end else if (!stall) begin
                  if (r_skid_valid) begin
                     r_ifid_valid <= 1'b1;
                     r_ifid_instr <= r_skid_instr;
                     r_ifid_pc    <= r_skid_pc;
                     r_opcode     <= r_skid_instr[6:0];
                     r_skid_valid <= 1'b0;
                     r_req        <= 1'b1;
                  end else begin
                     r_ifid_valid <= 1'b0;
                     r_opcode     <= 7'b000_0000;
                  end
               end else begin
                  r_ifid_valid <= r_ifid_valid;
               end
            end

            S_DRAIN: begin
               if (branch_taken) begin
                  r_pc <= w_target;
                  if (imem_ack) begin
                     r_state <= S_FETCH;
                     r_addr  <= w_target;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else if (imem_ack) begin
                  // stale data is dropped; IF/ID stays invalid
                  r_state <= S_FETCH;
                  r_addr  <= r_pc;
               end else begin
                  r_state <= S_DRAIN;
               end
            end

            default: begin
               r_state      <= S_BOOT;
               r_req        <= 1'b0;
               r_ifid_valid <= 1'b0;
               r_opcode     <= 7'b000_0000;
               r_skid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0000_0000;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        IF_ID_valid;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pc;
   logic [6:0]  OPcode;

   logic        ack_en;
   logic        stray;
   int          checks   = 0;
   int          failures = 0;

   instr_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .IF_ID_valid   (IF_ID_valid),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_pc      (IF_ID_pc),
      .OPcode        (OPcode)
   );

   always #5 clk = ~clk;

   // memory contents: two fixed words at 0/4, otherwise addr + 0x10000003
   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == 32'h0000_0000)      word = 32'h0000_0033;
      else if (a == 32'h0000_0004) word = 32'h00A0_0093;
      else                         word = a + 32'h1000_0003;
   endfunction

   // memory model: answers one cycle after a request is seen when enabled
   always @(negedge clk) begin
      imem_ack   = (imem_req & ack_en) | stray;
      imem_rdata = word(imem_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0000_0000; ack_en = 1'b1; stray = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0000_0000; ack_en = 1'b1; stray = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0 || OPcode !== 7'h00 ||
          IF_ID_instr !== 32'h0 || IF_ID_pc !== 32'h0 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_state req=%b valid=%b op=%h instr=%h pc=%h addr=%h expected all zero",
                  imem_req, IF_ID_valid, OPcode, IF_ID_instr, IF_ID_pc, imem_addr);
      end
      rst_n = 1'b1;
      // the cycle before the first edge is BOOT: no request yet
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++;
         $display("FAIL boot_no_req got=%b expected=0", imem_req);
      end
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || IF_ID_valid !== 1'b0) begin
         failures++;
         $display("FAIL first_req req=%b addr=%h valid=%b expected 1/00000000/0",
                  imem_req, imem_addr, IF_ID_valid);
      end
   endtask

   task automatic test_fetch_seq();
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h0 || IF_ID_instr !== 32'h0000_0033 || OPcode !== 7'h33) begin
         failures++;
         $display("FAIL seq_word0 valid=%b pc=%h instr=%h op=%h expected 1/00000000/00000033/33",
                  IF_ID_valid, IF_ID_pc, IF_ID_instr, OPcode);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h4 || IF_ID_instr !== 32'h00A0_0093 || OPcode !== 7'h13) begin
         failures++;
         $display("FAIL seq_word1 valid=%b pc=%h instr=%h op=%h expected 1/00000004/00a00093/13",
                  IF_ID_valid, IF_ID_pc, IF_ID_instr, OPcode);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (IF_ID_pc !== 32'h4 || IF_ID_instr !== 32'h00A0_0093 || IF_ID_valid !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d pc=%h instr=%h valid=%b req=%b expected 00000004/00a00093/1/0",
                     i, IF_ID_pc, IF_ID_instr, IF_ID_valid, imem_req);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if (IF_ID_pc !== 32'h8 || IF_ID_instr !== 32'h1000_000B || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
         failures++;
         $display("FAIL stall_skid_out pc=%h instr=%h req=%b addr=%h expected 00000008/1000000b/1/0000000c",
                  IF_ID_pc, IF_ID_instr, imem_req, imem_addr);
      end
      step();
      checks++;
      if (IF_ID_pc !== 32'hC || IF_ID_instr !== 32'h1000_000F || IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_next pc=%h instr=%h valid=%b expected 0000000c/1000000f/1",
                  IF_ID_pc, IF_ID_instr, IF_ID_valid);
      end
   endtask

   task automatic test_branch_drain();
      do_reset();
      step(); step(); step();          // boot, word 0, word 4; request for 0x8 now live
      ack_en = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100;
      step();
      branch_taken = 1'b0;
      checks++;
      if (IF_ID_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         failures++;
         $display("FAIL drain_enter valid=%b req=%b addr=%h expected 0/1/00000008",
                  IF_ID_valid, imem_req, imem_addr);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_wait valid=%b expected 0", IF_ID_valid);
      end
      ack_en = 1'b1;
      step();
      checks++;
      if (IF_ID_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
         failures++;
         $display("FAIL drain_done valid=%b addr=%h req=%b expected 0/00000100/1",
                  IF_ID_valid, imem_addr, imem_req);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h100 || IF_ID_instr !== 32'h1000_0103 || OPcode !== 7'h03) begin
         failures++;
         $display("FAIL drain_target valid=%b pc=%h instr=%h op=%h expected 1/00000100/10000103/03",
                  IF_ID_valid, IF_ID_pc, IF_ID_instr, OPcode);
      end
   endtask

   task automatic test_branch_ack_stall();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
      step();
      checks++;
      if (IF_ID_valid !== 1'b0 || OPcode !== 7'h00 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
         failures++;
         $display("FAIL br_ack_stall valid=%b op=%h addr=%h req=%b expected 0/00/00000100/1",
                  IF_ID_valid, OPcode, imem_addr, imem_req);
      end
      stall = 1'b0; branch_taken = 1'b0;
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h100 || imem_addr !== 32'h104) begin
         failures++;
         $display("FAIL br_ack_refetch valid=%b pc=%h addr=%h expected 1/00000100/00000104",
                  IF_ID_valid, IF_ID_pc, imem_addr);
      end
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC || IF_ID_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_setup addr=%h valid=%b expected fffffffc/0", imem_addr, IF_ID_valid);
      end
      step();
      checks++;
      if (imem_addr !== 32'h0 || IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_instr !== 32'h0FFF_FFFF || OPcode !== 7'h7F) begin
         failures++;
         $display("FAIL wrap_pc addr=%h pc=%h instr=%h op=%h expected 00000000/fffffffc/0fffffff/7f",
                  imem_addr, IF_ID_pc, IF_ID_instr, OPcode);
      end
      branch_taken = 1'b1; branch_target = 32'h0000_0103;
      step();
      branch_taken = 1'b0;
      checks++;
      if (imem_addr !== 32'h100) begin
         failures++;
         $display("FAIL target_align addr=%h expected 00000100", imem_addr);
      end
   endtask

   task automatic test_async_reset_stray();
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0 || imem_addr !== 32'h0 ||
          IF_ID_pc !== 32'h0 || IF_ID_instr !== 32'h0 || OPcode !== 7'h00) begin
         failures++;
         $display("FAIL async_reset req=%b valid=%b addr=%h pc=%h instr=%h op=%h expected all zero",
                  imem_req, IF_ID_valid, imem_addr, IF_ID_pc, IF_ID_instr, OPcode);
      end
      ack_en = 1'b0; stray = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      stray = 1'b0;
      checks++;
      if (IF_ID_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL stray_boot valid=%b req=%b addr=%h expected 0/1/00000000",
                  IF_ID_valid, imem_req, imem_addr);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b0 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL stray_after valid=%b addr=%h expected 0/00000000", IF_ID_valid, imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_seq();
      test_stall();
      test_branch_drain();
      test_branch_ack_stall();
      test_wrap();
      test_async_reset_stray();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
